// File: rtl/simt_regfile_pkg.sv
// simt_regfile_pkg: shared encodings for the SIMT register file.
//   core_state_e - core FSM state codes as seen on the core_state input
//   reg_mux_e    - register write source select codes
//   RO_*         - layout of the read-only specials at the top of each lane
package simt_regfile_pkg;

   typedef enum logic [2:0] {
      CoreIdle    = 3'b000,
      CoreFetch   = 3'b001,
      CoreDecode  = 3'b010,
      CoreRequest = 3'b011,
      CoreWait    = 3'b100,
      CoreExecute = 3'b101,
      CoreUpdate  = 3'b110,
      CoreDone    = 3'b111
   } core_state_e;

   typedef enum logic [2:0] {
      MuxAlu   = 3'b000,
      MuxMem   = 3'b001,
      MuxConst = 3'b010,
      MuxFma   = 3'b011,
      MuxAct   = 3'b100
   } reg_mux_e;

   // Specials live at NUM_REGS - offset.
   localparam int unsigned RO_REG_COUNT      = 3;
   localparam int unsigned RO_BLOCK_IDX_OFS  = 3;
   localparam int unsigned RO_BLOCK_DIM_OFS  = 2;
   localparam int unsigned RO_THREAD_IDX_OFS = 1;

   // MEM data arrives through the writeback port, never in UPDATE; 101-111 are no-ops.
   function automatic logic mux_writes_in_update(input logic [2:0] sel);
      return sel inside {MuxAlu, MuxConst, MuxFma, MuxAct};
   endfunction

endpackage

// File: rtl/simt_register_file_if.sv
// simt_register_file_if: load-data return bus from the LSU into the register file.
//   lsu_wb_valid - data return strobe
//   lsu_wb_rd    - destination register
//   lsu_wb_mask  - lanes carrying data
//   lsu_wb_data  - per-lane data, lane i at [i*DATA_BITS +: DATA_BITS]
// master: LSU side (drives), slave: register file side (receives).
interface simt_register_file_if #(
   parameter int unsigned THREADS_PER_BLOCK = 4,
   parameter int unsigned DATA_BITS         = 16,
   parameter int unsigned ADDR_BITS         = 4
) ();

   logic                                   lsu_wb_valid;
   logic [ADDR_BITS-1:0]                   lsu_wb_rd;
   logic [THREADS_PER_BLOCK-1:0]           lsu_wb_mask;
   logic [THREADS_PER_BLOCK*DATA_BITS-1:0] lsu_wb_data;

   modport master (
      output lsu_wb_valid,
      output lsu_wb_rd,
      output lsu_wb_mask,
      output lsu_wb_data
   );

   modport slave (
      input lsu_wb_valid,
      input lsu_wb_rd,
      input lsu_wb_mask,
      input lsu_wb_data
   );

endinterface

// File: rtl/simt_regfile_lane.sv
// simt_regfile_lane: storage and read ports for one thread lane.
//   clk, reset           - clock, async active-high reset
//   lane_enable          - this lane is active (gates writes and reads)
//   block_start/block_id - reload %blockIdx
//   upd_we/addr/data     - UPDATE-stage write (already qualified as writable)
//   wb_we/addr/data      - load writeback for this lane (already masked, writable)
//   rs/rt/rd _addr       - read addresses; rs, rt, rd_data - combinational reads
module simt_regfile_lane
   import simt_regfile_pkg::*;
#(
   parameter int unsigned LANE_ID           = 0,
   parameter int unsigned THREADS_PER_BLOCK = 4,
   parameter int unsigned DATA_BITS         = 16,
   parameter int unsigned NUM_REGS          = 16,
   localparam int unsigned ADDR_BITS        = $clog2(NUM_REGS)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 lane_enable,
   input  logic                 block_start,
   input  logic [7:0]           block_id,
   input  logic                 upd_we,
   input  logic [ADDR_BITS-1:0] upd_addr,
   input  logic [DATA_BITS-1:0] upd_data,
   input  logic                 wb_we,
   input  logic [ADDR_BITS-1:0] wb_addr,
   input  logic [DATA_BITS-1:0] wb_data,
   input  logic [ADDR_BITS-1:0] rs_addr,
   input  logic [ADDR_BITS-1:0] rt_addr,
   input  logic [ADDR_BITS-1:0] rd_addr,
   output logic [DATA_BITS-1:0] rs,
   output logic [DATA_BITS-1:0] rt,
   output logic [DATA_BITS-1:0] rd_data
);

   localparam int unsigned NUM_FREE = NUM_REGS - RO_REG_COUNT;

   logic [DATA_BITS-1:0] free_q [NUM_FREE];
   logic [DATA_BITS-1:0] block_idx_q;

   logic upd_lane;
   logic wb_lane;

   assign upd_lane = upd_we & lane_enable;
   assign wb_lane  = wb_we & lane_enable;

   // Two write ports; on the same register the UPDATE value takes priority.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(NUM_FREE); i++) begin
            free_q[i] <= '0;
         end
         block_idx_q <= '0;
      end else begin
         if (block_start) begin
            block_idx_q <= DATA_BITS'(block_id);
         end
         for (int i = 0; i < int'(NUM_FREE); i++) begin
            if (upd_lane && (upd_addr == ADDR_BITS'(i))) begin
               free_q[i] <= upd_data;
            end else if (wb_lane && (wb_addr == ADDR_BITS'(i))) begin
               free_q[i] <= wb_data;
            end
         end
      end
   end

   function automatic logic [DATA_BITS-1:0] read_reg(input logic [ADDR_BITS-1:0] addr);
      logic [DATA_BITS-1:0] val;
      if (addr < ADDR_BITS'(NUM_FREE)) begin
         val = free_q[addr];
      end else if (addr == ADDR_BITS'(NUM_REGS - RO_BLOCK_IDX_OFS)) begin
         val = block_idx_q;
      end else if (addr == ADDR_BITS'(NUM_REGS - RO_BLOCK_DIM_OFS)) begin
         val = DATA_BITS'(THREADS_PER_BLOCK);
      end else begin
         val = DATA_BITS'(LANE_ID);
      end
      return val;
   endfunction

   always_comb begin
      rs      = '0;
      rt      = '0;
      rd_data = '0;
      if (lane_enable) begin
         rs      = read_reg(rs_addr);
         rt      = read_reg(rt_addr);
         rd_data = read_reg(rd_addr);
      end
   end

endmodule

// File: rtl/simt_register_file.sv
// simt_register_file: per-core register file for all lanes of a block, with a
// pending scoreboard for decoupled load writeback.
//   clk, reset               - clock, async active-high reset
//   thread_enable            - per-lane active mask
//   block_start, block_id    - new block issue; reloads %blockIdx, clears pending
//   core_state               - core FSM state (REQUEST issues loads, UPDATE writes)
//   decoded_*                - decoded register addresses, write enable, source, immediate
//   alu_out, fma_out, act_out- per-lane results
//   wb                       - load writeback bus (slave)
//   rs, rt, rd_data          - combinational per-lane reads
//   hazard                   - decoded rs/rt/rd has a load outstanding
//   pending_any              - any load outstanding
//   wb_conflict              - one-cycle pulse: UPDATE and writeback hit the same register
module simt_register_file
   import simt_regfile_pkg::*;
#(
   parameter int unsigned THREADS_PER_BLOCK = 4,
   parameter int unsigned DATA_BITS         = 16,
   parameter int unsigned NUM_REGS          = 16,
   parameter int unsigned NUM_RO_REGS       = 3,
   parameter int unsigned IMM_BITS          = 8,
   localparam int unsigned ADDR_BITS        = $clog2(NUM_REGS)
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic [THREADS_PER_BLOCK-1:0]           thread_enable,
   input  logic                                   block_start,
   input  logic [7:0]                             block_id,
   input  logic [2:0]                             core_state,
   input  logic [ADDR_BITS-1:0]                   decoded_rd_address,
   input  logic [ADDR_BITS-1:0]                   decoded_rs_address,
   input  logic [ADDR_BITS-1:0]                   decoded_rt_address,
   input  logic                                   decoded_reg_write_enable,
   input  logic [2:0]                             decoded_reg_input_mux,
   input  logic [IMM_BITS-1:0]                    decoded_immediate,
   input  logic [THREADS_PER_BLOCK*DATA_BITS-1:0] alu_out,
   input  logic [THREADS_PER_BLOCK*DATA_BITS-1:0] fma_out,
   input  logic [THREADS_PER_BLOCK*DATA_BITS-1:0] act_out,
   simt_register_file_if.slave                    wb,
   output logic [THREADS_PER_BLOCK*DATA_BITS-1:0] rs,
   output logic [THREADS_PER_BLOCK*DATA_BITS-1:0] rt,
   output logic [THREADS_PER_BLOCK*DATA_BITS-1:0] rd_data,
   output logic                                   hazard,
   output logic                                   pending_any,
   output logic                                   wb_conflict
);

   localparam int unsigned NUM_FREE = NUM_REGS - NUM_RO_REGS;

   logic                 rd_writable;
   logic                 wb_writable;
   logic                 upd_we;
   logic                 issue;
   logic                 wb_we;
   logic [DATA_BITS-1:0] imm_ext;

   logic [NUM_REGS-1:0]  pending_q, pending_d;
   logic                 wb_conflict_q, wb_conflict_d;

   assign rd_writable = decoded_rd_address < ADDR_BITS'(NUM_FREE);
   assign wb_writable = wb.lsu_wb_rd < ADDR_BITS'(NUM_FREE);

   assign upd_we = (core_state == CoreUpdate) && decoded_reg_write_enable && rd_writable &&
                   mux_writes_in_update(decoded_reg_input_mux);
   assign issue  = (core_state == CoreRequest) && decoded_reg_write_enable && rd_writable &&
                   (decoded_reg_input_mux == MuxMem);
   assign wb_we  = wb.lsu_wb_valid && wb_writable;

   assign imm_ext = DATA_BITS'($signed(decoded_immediate));

   // Later assignments win: block_start clears, writeback retires, a fresh issue re-arms.
   always_comb begin
      pending_d = pending_q;
      if (block_start) begin
         pending_d = '0;
      end
      if (wb_we) begin
         pending_d[wb.lsu_wb_rd] = 1'b0;
      end
      if (issue) begin
         pending_d[decoded_rd_address] = 1'b1;
      end
   end

   // Only a real collision counts: some lane would have taken both writes.
   assign wb_conflict_d = upd_we && wb_we && (decoded_rd_address == wb.lsu_wb_rd) &&
                          |(wb.lsu_wb_mask & thread_enable);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending_q     <= '0;
         wb_conflict_q <= 1'b0;
      end else begin
         pending_q     <= pending_d;
         wb_conflict_q <= wb_conflict_d;
      end
   end

   assign hazard      = pending_q[decoded_rs_address] | pending_q[decoded_rt_address] |
                        pending_q[decoded_rd_address];
   assign pending_any = |pending_q;
   assign wb_conflict = wb_conflict_q;

   for (genvar i = 0; i < int'(THREADS_PER_BLOCK); i++) begin : g_lane
      logic [DATA_BITS-1:0] upd_src;

      always_comb begin
         upd_src = '0;
         case (decoded_reg_input_mux)
            MuxAlu:   upd_src = alu_out[i*DATA_BITS +: DATA_BITS];
            MuxConst: upd_src = imm_ext;
            MuxFma:   upd_src = fma_out[i*DATA_BITS +: DATA_BITS];
            MuxAct:   upd_src = act_out[i*DATA_BITS +: DATA_BITS];
            default:  upd_src = '0;
         endcase
      end

      simt_regfile_lane #(
         .LANE_ID           (i),
         .THREADS_PER_BLOCK (THREADS_PER_BLOCK),
         .DATA_BITS         (DATA_BITS),
         .NUM_REGS          (NUM_REGS)
      ) u_lane (
         .clk         (clk),
         .reset       (reset),
         .lane_enable (thread_enable[i]),
         .block_start (block_start),
         .block_id    (block_id),
         .upd_we      (upd_we),
         .upd_addr    (decoded_rd_address),
         .upd_data    (upd_src),
         .wb_we       (wb_we & wb.lsu_wb_mask[i]),
         .wb_addr     (wb.lsu_wb_rd),
         .wb_data     (wb.lsu_wb_data[i*DATA_BITS +: DATA_BITS]),
         .rs_addr     (decoded_rs_address),
         .rt_addr     (decoded_rt_address),
         .rd_addr     (decoded_rd_address),
         .rs          (rs[i*DATA_BITS +: DATA_BITS]),
         .rt          (rt[i*DATA_BITS +: DATA_BITS]),
         .rd_data     (rd_data[i*DATA_BITS +: DATA_BITS])
      );
   end

endmodule

// File: tb/tb_simt_register_file.sv
module tb_simt_register_file;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int tests  = 0;
   int failed = 0;

   // ---------------- default instance: 4 lanes x 16 regs x 16 bits ----------------
   logic [3:0]  en;
   logic        bs;
   logic [7:0]  bid;
   logic [2:0]  cs;
   logic [3:0]  rd_a, rs_a, rt_a;
   logic        we;
   logic [2:0]  mux;
   logic [7:0]  imm;
   logic [63:0] alu, fma, act;
   logic [63:0] rs_o, rt_o, rdd_o;
   logic        haz, pany, wconf;

   simt_register_file_if #(.THREADS_PER_BLOCK(4), .DATA_BITS(16), .ADDR_BITS(4)) wbif ();

   simt_register_file dut (
      .clk                      (clk),
      .reset                    (reset),
      .thread_enable            (en),
      .block_start              (bs),
      .block_id                 (bid),
      .core_state               (cs),
      .decoded_rd_address       (rd_a),
      .decoded_rs_address       (rs_a),
      .decoded_rt_address       (rt_a),
      .decoded_reg_write_enable (we),
      .decoded_reg_input_mux    (mux),
      .decoded_immediate        (imm),
      .alu_out                  (alu),
      .fma_out                  (fma),
      .act_out                  (act),
      .wb                       (wbif),
      .rs                       (rs_o),
      .rt                       (rt_o),
      .rd_data                  (rdd_o),
      .hazard                   (haz),
      .pending_any              (pany),
      .wb_conflict              (wconf)
   );

   // ---------------- wide instance: 8 lanes x 32 regs x 32 bits ----------------
   logic [7:0]   en8;
   logic         bs8;
   logic [7:0]   bid8;
   logic [2:0]   cs8;
   logic [4:0]   rd8, rs8, rt8;
   logic         we8;
   logic [2:0]   mux8;
   logic [7:0]   imm8;
   logic [255:0] alu8, fma8, act8;
   logic [255:0] rs8_o, rt8_o, rdd8_o;
   logic         haz8, pany8, wconf8;

   simt_register_file_if #(.THREADS_PER_BLOCK(8), .DATA_BITS(32), .ADDR_BITS(5)) wbif8 ();

   simt_register_file #(
      .THREADS_PER_BLOCK (8),
      .DATA_BITS         (32),
      .NUM_REGS          (32),
      .NUM_RO_REGS       (3),
      .IMM_BITS          (8)
   ) dut8 (
      .clk                      (clk),
      .reset                    (reset),
      .thread_enable            (en8),
      .block_start              (bs8),
      .block_id                 (bid8),
      .core_state               (cs8),
      .decoded_rd_address       (rd8),
      .decoded_rs_address       (rs8),
      .decoded_rt_address       (rt8),
      .decoded_reg_write_enable (we8),
      .decoded_reg_input_mux    (mux8),
      .decoded_immediate        (imm8),
      .alu_out                  (alu8),
      .fma_out                  (fma8),
      .act_out                  (act8),
      .wb                       (wbif8),
      .rs                       (rs8_o),
      .rt                       (rt8_o),
      .rd_data                  (rdd8_o),
      .hazard                   (haz8),
      .pending_any              (pany8),
      .wb_conflict              (wconf8)
   );

   // ---------------- reference model (default instance) ----------------
   // m_reg[lane][r]: 0..12 free, 13 blockIdx, 14 blockDim, 15 threadIdx.
   logic [15:0] m_reg [4][16];
   bit          m_pend [16];
   bit          m_conf;

   task automatic model_reset();
      for (int l = 0; l < 4; l++) begin
         for (int r = 0; r < 16; r++) m_reg[l][r] = 16'h0000;
         m_reg[l][14] = 16'd4;
         m_reg[l][15] = 16'(l);
      end
      for (int r = 0; r < 16; r++) m_pend[r] = 1'b0;
      m_conf = 1'b0;
   endtask

   // Applies one clock edge worth of the register-file rules to the model.
   task automatic model_clock();
      bit          upd_ok, wb_ok, conf;
      logic [15:0] src;
      upd_ok = (cs == 3'b110) && we && (rd_a < 4'd13) &&
               (mux == 3'b000 || mux == 3'b010 || mux == 3'b011 || mux == 3'b100);
      wb_ok  = wbif.lsu_wb_valid && (wbif.lsu_wb_rd < 4'd13);
      conf   = 1'b0;
      case (mux)
         3'b010:  src = {{8{imm[7]}}, imm};
         default: src = 16'h0000;
      endcase
      for (int l = 0; l < 4; l++) begin
         if (mux == 3'b000) src = alu[l*16 +: 16];
         if (mux == 3'b011) src = fma[l*16 +: 16];
         if (mux == 3'b100) src = act[l*16 +: 16];
         if (bs) m_reg[l][13] = {8'h00, bid};
         if (wb_ok && wbif.lsu_wb_mask[l] && en[l]) begin
            m_reg[l][wbif.lsu_wb_rd] = wbif.lsu_wb_data[l*16 +: 16];
            if (upd_ok && rd_a == wbif.lsu_wb_rd) conf = 1'b1;
         end
         // Applied after the writeback so the UPDATE value wins on collision.
         if (upd_ok && en[l]) m_reg[l][rd_a] = src;
      end
      if (bs) for (int r = 0; r < 16; r++) m_pend[r] = 1'b0;
      if (wb_ok) m_pend[wbif.lsu_wb_rd] = 1'b0;
      if (cs == 3'b011 && we && mux == 3'b001 && rd_a < 4'd13) m_pend[rd_a] = 1'b1;
      m_conf = conf;
   endtask

   function automatic logic [63:0] exp_read(input logic [3:0] a);
      logic [63:0] v;
      for (int l = 0; l < 4; l++) v[l*16 +: 16] = en[l] ? m_reg[l][a] : 16'h0000;
      return v;
   endfunction

   function automatic logic exp_pany();
      logic p = 1'b0;
      for (int r = 0; r < 16; r++) p |= m_pend[r];
      return p;
   endfunction

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      assert (got === exp)
      else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idle();
      bs = 1'b0;
      cs = 3'b000;
      we = 1'b0;
      mux = 3'b000;
      wbif.lsu_wb_valid = 1'b0;
      wbif.lsu_wb_rd = 4'd0;
      wbif.lsu_wb_mask = 4'h0;
      wbif.lsu_wb_data = 64'h0;
   endtask

   task automatic idle8();
      bs8 = 1'b0;
      cs8 = 3'b000;
      we8 = 1'b0;
      mux8 = 3'b000;
      wbif8.lsu_wb_valid = 1'b0;
      wbif8.lsu_wb_rd = 5'd0;
      wbif8.lsu_wb_mask = 8'h00;
      wbif8.lsu_wb_data = '0;
   endtask

   // One clock edge with the currently driven inputs; checks the conflict pulse.
   task automatic step();
      @(posedge clk);
      model_clock();
      #1;
      check("wb_conflict", {63'h0, wconf}, {63'h0, m_conf});
   endtask

   // Sweeps every address through all three read ports while inputs are idle.
   task automatic check_all(input string tag);
      for (int a = 0; a < 16; a++) begin
         @(negedge clk);
         rs_a = 4'(a);
         rt_a = 4'(15 - a);
         rd_a = 4'(a + 5);
         #2;
         check({tag, "_rs"}, rs_o, exp_read(rs_a));
         check({tag, "_rt"}, rt_o, exp_read(rt_a));
         check({tag, "_rd"}, rdd_o, exp_read(rd_a));
         check({tag, "_hazard"}, {63'h0, haz},
               {63'h0, m_pend[rs_a] | m_pend[rt_a] | m_pend[rd_a]});
      end
      check({tag, "_pending_any"}, {63'h0, pany}, {63'h0, exp_pany()});
   endtask

   logic [31:0] d8 [8];

   initial begin
      reset = 1'b1;
      idle();
      idle8();
      en = 4'hF; bid = 8'h00; rd_a = 4'd0; rs_a = 4'd0; rt_a = 4'd0; imm = 8'h00;
      alu = '0; fma = '0; act = '0;
      en8 = 8'hFF; bid8 = 8'h00; rd8 = 5'd0; rs8 = 5'd0; rt8 = 5'd0; imm8 = 8'h00;
      alu8 = '0; fma8 = '0; act8 = '0;
      model_reset();

      // Reset values
      #3;
      rs_a = 4'd13; rt_a = 4'd14; rd_a = 4'd15;
      #1;
      check("rst_blockidx_l2", {48'h0, rs_o[47:32]}, 64'h0000);
      check("rst_blockdim_l2", {48'h0, rt_o[47:32]}, 64'h0004);
      check("rst_threadidx_l2", {48'h0, rdd_o[47:32]}, 64'h0002);
      check("rst_pending_any", {63'h0, pany}, 64'h0);
      @(negedge clk);
      reset = 1'b0;
      check_all("reset");

      // CONST sign extension with lane 2 masked off
      en = 4'b1011; cs = 3'b110; we = 1'b1; mux = 3'b010; imm = 8'hFF; rd_a = 4'd3;
      step(); idle();
      rs_a = 4'd3;
      #1;
      check("const_masked", rs_o, 64'hFFFF_0000_FFFF_FFFF);
      en = 4'hF;
      #1;
      check("const_lane2_kept", {48'h0, rs_o[47:32]}, 64'h0000);
      check_all("const");

      // MEM in UPDATE writes nothing
      cs = 3'b110; we = 1'b1; mux = 3'b001; rd_a = 4'd6;
      step(); idle();
      rs_a = 4'd6;
      #1;
      check("mem_update_nowrite", rs_o, 64'h0);

      // Load scoreboard
      cs = 3'b011; we = 1'b1; mux = 3'b001; rd_a = 4'd5;
      step(); idle();
      rs_a = 4'd5; rt_a = 4'd0; rd_a = 4'd0;
      #1;
      check("load_hazard_set", {63'h0, haz}, 64'h1);
      check("load_pending_any", {63'h0, pany}, 64'h1);
      wbif.lsu_wb_valid = 1'b1; wbif.lsu_wb_rd = 4'd5; wbif.lsu_wb_mask = 4'hF;
      wbif.lsu_wb_data = 64'hDEF0_9ABC_5678_1234;
      step(); idle();
      rs_a = 4'd5; rt_a = 4'd0; rd_a = 4'd0;
      #1;
      check("load_hazard_clear", {63'h0, haz}, 64'h0);
      check("load_data", rs_o, 64'hDEF0_9ABC_5678_1234);
      check_all("load");

      // Read-only protection and block_start
      cs = 3'b110; we = 1'b1; mux = 3'b000; rd_a = 4'd13; alu = {4{16'h7FFF}};
      step(); idle();
      rs_a = 4'd13;
      #1;
      check("ro_update_dropped", rs_o, 64'h0);
      bs = 1'b1; bid = 8'h2A;
      step(); idle();
      rs_a = 4'd13;
      #1;
      check("block_idx_loaded", rs_o, {4{16'h002A}});
      wbif.lsu_wb_valid = 1'b1; wbif.lsu_wb_rd = 4'd14; wbif.lsu_wb_mask = 4'hF;
      wbif.lsu_wb_data = {4{16'hBEEF}};
      step(); idle();
      rs_a = 4'd14;
      #1;
      check("ro_wb_dropped", rs_o, {4{16'h0004}});

      // Issue and writeback to the same register
      cs = 3'b011; we = 1'b1; mux = 3'b001; rd_a = 4'd7;
      wbif.lsu_wb_valid = 1'b1; wbif.lsu_wb_rd = 4'd7; wbif.lsu_wb_mask = 4'hF;
      wbif.lsu_wb_data = 64'h1111_2222_3333_4444;
      step(); idle();
      rs_a = 4'd7; rt_a = 4'd0; rd_a = 4'd0;
      #1;
      check("issue_wb_data", rs_o, 64'h1111_2222_3333_4444);
      check("issue_wb_pending", {63'h0, haz}, 64'h1);

      // UPDATE and writeback to the same register
      cs = 3'b110; we = 1'b1; mux = 3'b000; rd_a = 4'd4; alu = {4{16'h0001}};
      wbif.lsu_wb_valid = 1'b1; wbif.lsu_wb_rd = 4'd4; wbif.lsu_wb_mask = 4'hF;
      wbif.lsu_wb_data = {4{16'h0002}};
      step();
      check("conflict_pulse_hi", {63'h0, wconf}, 64'h1);
      idle();
      rs_a = 4'd4;
      #1;
      check("conflict_update_wins", rs_o, {4{16'h0001}});
      @(posedge clk);
      #1;
      check("conflict_pulse_lo", {63'h0, wconf}, 64'h0);

      // block_start and issue together: the issue survives, older pending is cleared
      bs = 1'b1; bid = 8'h07; cs = 3'b011; we = 1'b1; mux = 3'b001; rd_a = 4'd8;
      step(); idle();
      rs_a = 4'd8; rt_a = 4'd0; rd_a = 4'd0;
      #1;
      check("bs_issue_set", {63'h0, haz}, 64'h1);
      rs_a = 4'd7;
      #1;
      check("bs_clears_old", {63'h0, haz}, 64'h0);
      check_all("bs_issue");

      // Reset mid-load, then a late writeback still writes data
      cs = 3'b011; we = 1'b1; mux = 3'b001; rd_a = 4'd9;
      step(); idle();
      reset = 1'b1;
      model_reset();
      #2;
      check("reset_mid_load", {63'h0, pany}, 64'h0);
      @(negedge clk);
      reset = 1'b0;
      wbif.lsu_wb_valid = 1'b1; wbif.lsu_wb_rd = 4'd9; wbif.lsu_wb_mask = 4'hF;
      wbif.lsu_wb_data = 64'hCAFE_F00D_0BAD_D00D;
      step(); idle();
      rs_a = 4'd9;
      #1;
      check("late_wb_data", rs_o, 64'hCAFE_F00D_0BAD_D00D);
      check("late_wb_pending", {63'h0, pany}, 64'h0);

      // Randomized traffic against the model
      for (int it = 0; it < 150; it++) begin
         en   = 4'($urandom);
         cs   = 3'($urandom);
         we   = 1'($urandom);
         mux  = 3'($urandom);
         rd_a = 4'($urandom);
         rs_a = 4'($urandom);
         rt_a = 4'($urandom);
         imm  = 8'($urandom);
         alu  = {$urandom, $urandom};
         fma  = {$urandom, $urandom};
         act  = {$urandom, $urandom};
         bs   = ($urandom_range(0, 15) == 0);
         bid  = 8'($urandom);
         wbif.lsu_wb_valid = 1'($urandom);
         wbif.lsu_wb_rd    = ($urandom_range(0, 1) == 1) ? rd_a : 4'($urandom);
         wbif.lsu_wb_mask  = 4'($urandom);
         wbif.lsu_wb_data  = {$urandom, $urandom};
         step(); idle();
         check_all("rand");
      end

      // Wide instance: specials and the load scoreboard
      @(negedge clk);
      rs8 = 5'd31; rt8 = 5'd30;
      #1;
      check("p8_threadidx_l7", {32'h0, rs8_o[255:224]}, 64'd7);
      check("p8_threadidx_l3", {32'h0, rs8_o[127:96]}, 64'd3);
      check("p8_blockdim_l0", {32'h0, rt8_o[31:0]}, 64'd8);
      check("p8_blockdim_l7", {32'h0, rt8_o[255:224]}, 64'd8);
      cs8 = 3'b011; we8 = 1'b1; mux8 = 3'b001; rd8 = 5'd5;
      @(posedge clk);
      #1;
      idle8();
      rs8 = 5'd5; rt8 = 5'd0; rd8 = 5'd0;
      #1;
      check("p8_hazard_set", {63'h0, haz8}, 64'h1);
      check("p8_pending_any", {63'h0, pany8}, 64'h1);
      wbif8.lsu_wb_valid = 1'b1; wbif8.lsu_wb_rd = 5'd5; wbif8.lsu_wb_mask = 8'hFF;
      for (int l = 0; l < 8; l++) begin
         d8[l] = $urandom;
         wbif8.lsu_wb_data[l*32 +: 32] = d8[l];
      end
      @(posedge clk);
      #1;
      idle8();
      rs8 = 5'd5;
      #1;
      check("p8_hazard_clear", {63'h0, haz8}, 64'h0);
      for (int l = 0; l < 8; l++) begin
         check("p8_load_data", {32'h0, rs8_o[l*32 +: 32]}, {32'h0, d8[l]});
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/simt_register_file.md
Name: simt_register_file

Overview:
- Per-core register file for all threads of a block: one lane of NUM_REGS x DATA_BITS registers per thread.
- The top NUM_RO_REGS registers of each lane are read-only specials: %blockIdx, %blockDim, %threadIdx.
- Generalises the per-thread file in three ways: width, register count and lane count are all parameters.
- It also adds decoupled load writeback with a per-register pending scoreboard, so loads retire out of the UPDATE stage and the core can stall on RAW/WAW hazards.

Parameters:
- THREADS_PER_BLOCK, 4, number of lanes.
- DATA_BITS, 16, register width (Q1.15 default).
- NUM_REGS, 16, registers per lane; power of two, at least 4.
- NUM_RO_REGS, 3, read-only registers at indices NUM_REGS-3..NUM_REGS-1; fixed at 3.
- IMM_BITS, 8, immediate width; IMM_BITS <= DATA_BITS.
- ADDR_BITS, $clog2(NUM_REGS), derived, not overridable.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- thread_enable  in  THREADS_PER_BLOCK  per-lane active mask.
- block_start  in  1  one-cycle pulse when the dispatcher issues a new block.
- block_id  in  8  block index, sampled on block_start.
- core_state  in  3  core FSM state.
- decoded_rd_address / decoded_rs_address / decoded_rt_address  in  ADDR_BITS each.
- decoded_reg_write_enable  in  1.
- decoded_reg_input_mux  in  3  source select.
- decoded_immediate  in  IMM_BITS.
- alu_out, fma_out, act_out  in  THREADS_PER_BLOCK*DATA_BITS each  per-lane results, lane i at [i*DATA_BITS +: DATA_BITS].
- lsu_wb_valid  in  1  load data return.
- lsu_wb_rd  in  ADDR_BITS  destination of the returning load.
- lsu_wb_mask  in  THREADS_PER_BLOCK  lanes carrying data.
- lsu_wb_data  in  THREADS_PER_BLOCK*DATA_BITS  returned load data.
- rs, rt, rd_data  out  THREADS_PER_BLOCK*DATA_BITS each  combinational reads.
- hazard  out  1  decoded rs, rt or rd is pending.
- pending_any  out  1  any register pending.
- wb_conflict  out  1  registered one-cycle error pulse.

Behaviour:
- Core state encoding: IDLE 000, FETCH 001, DECODE 010, REQUEST 011, WAIT 100, EXECUTE 101, UPDATE 110, DONE 111.
- Mux encoding: ALU 000, MEM 001, CONST 010, FMA 011, ACT 100; codes 101-111 perform no write.
- Reset (async assert, takes effect immediately):
  - all free registers cleared to 0;
  - %blockIdx = 0, %blockDim = THREADS_PER_BLOCK, %threadIdx = lane index, all zero-extended;
  - pending = 0, wb_conflict = 0.
- Reads: lane i output = register[addr] when thread_enable[i], else 0. Zero latency; a write is visible on the cycle after the clock edge.
- block_start: %blockIdx of every lane <= block_id, and pending is cleared. Free registers are untouched.
- UPDATE write: applies when core_state==UPDATE, decoded_reg_write_enable=1 and rd < NUM_REGS-NUM_RO_REGS.
  - Every enabled lane writes the source selected by the mux.
  - CONST writes decoded_immediate sign-extended to DATA_BITS.
  - MEM performs no write in UPDATE.
  - Writes to read-only indices are silently dropped.
- Load issue: when core_state==REQUEST, write enable=1, mux==MEM and rd is writable, set pending[rd].
- Writeback: when lsu_wb_valid=1 and lsu_wb_rd is writable, each lane with lsu_wb_mask&thread_enable writes its slice of lsu_wb_data, and pending[lsu_wb_rd] is cleared. A writeback to a read-only index is dropped and pending is unchanged.
- hazard = pending[rs] | pending[rt] | pending[rd], combinational, evaluated independently of core_state. pending_any = OR of pending.
- Simultaneous events:
  - Issue and writeback to the same register in the same cycle: the data is written and pending stays set, because the new load wins.
  - UPDATE write and writeback to the same register: the UPDATE value wins in overlapping lanes, and wb_conflict pulses high the next cycle.
  - block_start and issue in the same cycle: the issue wins, so the bit ends up set.
- Reset mid-load: pending is lost. Late writebacks after reset still write data; clearing already-cleared pending is harmless.

Decomposition:
- Package simt_regfile_pkg holds the core_state localparams (UPDATE, REQUEST), the mux encodings, and the read-only index offsets.
- Sub-module simt_regfile_lane: one lane's storage, read ports, and write arbitration between UPDATE and writeback. The lane ID is a parameter.
- The top level holds the scoreboard, wb_conflict and the generate loop over lanes.

Test Plan:
- Reset values: assert reset mid-sim and read addresses 13/14/15 on lane 2 -> 0x0000 / 0x0004 / 0x0002. All free registers read 0, pending_any=0.
- CONST sign-extension and lane masking: immediate 0xFF, rd=3, UPDATE, mask 4'b1011 -> R3 = 0xFFFF on lanes 0, 1 and 3; lane 2 keeps 0. Lane 2's read output stays 0 while it is disabled.
- Load scoreboard: issue LDR rd=5 in REQUEST -> hazard=1 when rs=5. Then writeback rd=5, mask 4'b1111, data 0x1234/0x5678/0x9ABC/0xDEF0 -> hazard=0 next cycle, R5 per lane matches.
- Read-only protection: UPDATE to rd=13 with ALU data 0x7FFF -> %blockIdx unchanged. A block_start with block_id=0x2A -> %blockIdx=0x002A on all lanes.
- Collisions:
  - Issue rd=7 and writeback rd=7 in the same cycle -> R7 updated, pending[7] still 1.
  - UPDATE ALU 0x0001 and writeback 0x0002 to rd=4 in the same cycle -> R4=0x0001, and wb_conflict pulses for exactly one cycle.
- Parametrisation: rerun the load scoreboard test with THREADS_PER_BLOCK=8, DATA_BITS=32, NUM_REGS=32 -> %blockDim=8 and %threadIdx=7 at index 31, and the scoreboard passes as before.
